// File: rtl/bit_pulse_shaper_pkg.sv
// Shared types and default sizing for the bit pulse shaper.
package bit_pulse_shaper_pkg;

  localparam int unsigned DefWidthBits = 4;
  localparam int unsigned DefCntWidth  = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StStretch = 2'd1,
    StDead    = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned width = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + width'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/bit_pulse_shaper.sv
// Turns rising edges of din into fixed-length, non-retriggerable pulses followed by an
// optional dead-time, counting accepted and rejected triggers.
module bit_pulse_shaper
  import bit_pulse_shaper_pkg::*;
#(
  parameter int unsigned WIDTH_BITS = DefWidthBits,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  din,
  input  logic                  enable,
  input  logic [WIDTH_BITS-1:0] width,
  input  logic [WIDTH_BITS-1:0] dead,
  input  logic                  cnt_clear,
  output logic                  q,
  output logic                  lead,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  lost_cnt
);

  state_e                state_d, state_q;
  logic [WIDTH_BITS-1:0] timer_d, timer_q;
  logic [WIDTH_BITS-1:0] dead_d, dead_q;
  logic                  din_ff_q;
  logic                  q_d, q_q;
  logic                  lead_d, lead_q;
  logic                  busy_d, busy_q;
  logic                  trigger, fire, accept, reject;

  assign trigger = din & ~din_ff_q;
  assign fire    = trigger & enable;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dead_d  = dead_q;
    q_d     = q_q;
    lead_d  = 1'b0;
    busy_d  = busy_q;
    accept  = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fire) begin
          accept  = 1'b1;
          state_d = StStretch;
          // Zero width behaves as one clock, so the timer starts at 0 either way.
          timer_d = (width == '0) ? '0 : width - WIDTH_BITS'(1);
          dead_d  = dead;
          q_d     = 1'b1;
          lead_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StStretch: begin
        reject = fire;
        if (timer_q == '0) begin
          q_d = 1'b0;
          if (dead_q != '0) begin
            state_d = StDead;
            timer_d = dead_q - WIDTH_BITS'(1);
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q - WIDTH_BITS'(1);
        end
      end
      StDead: begin
        reject = fire;
        if (timer_q == '0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          timer_d = timer_q - WIDTH_BITS'(1);
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
        q_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      dead_q   <= '0;
      din_ff_q <= 1'b0;
      q_q      <= 1'b0;
      lead_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      dead_q   <= dead_d;
      din_ff_q <= din;
      q_q      <= q_d;
      lead_q   <= lead_d;
      busy_q   <= busy_d;
    end
  end

  sat_counter #(
    .width(CNT_WIDTH)
  ) u_hit_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .inc    (accept),
    .count  (hit_cnt)
  );

  sat_counter #(
    .width(CNT_WIDTH)
  ) u_lost_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .inc    (reject),
    .count  (lost_cnt)
  );

  assign q    = q_q;
  assign lead = lead_q;
  assign busy = busy_q;

endmodule
